// File: rtl/cache_perf_ctrl.sv
// cache_perf_ctrl -- cache performance-counter control block.
//
// Counts read/write hit/miss events and serves a small control-register map
// through a valid/ready request port. Address 7 waits for the write-through
// buffer to drain, then pulses invalidate together with ready.
//
// Ports
//   clk, reset         : single rising-edge clock, synchronous active-high reset
//   valid, addr        : control request, held by the master until ready
//   wtbuf_full/_empty  : write-through buffer status
//   read_hit .. write_miss : per-cycle event strobes
//   rdata              : read data, zero whenever ready=0
//   ready              : one-cycle request acknowledge
//   invalidate         : one-cycle cache invalidate pulse
//
// Build option: define CACHE_PERF_SAT_EN to make the counters saturate at
// all-ones instead of wrapping to zero.

// One event-counter lane: clear beats increment, sticky overflow flag.
module cache_perf_evt_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
`ifdef CACHE_PERF_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

module cache_perf_ctrl #(
  parameter int FE_DATA_W   = 32,
  parameter int CNT_W       = 32,
  parameter int CTRL_ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [CTRL_ADDR_W-1:0] addr,
  input  logic                   wtbuf_full,
  input  logic                   wtbuf_empty,
  input  logic                   read_hit,
  input  logic                   read_miss,
  input  logic                   write_hit,
  input  logic                   write_miss,
  output logic [FE_DATA_W-1:0]   rdata,
  output logic                   ready,
  output logic                   invalidate
);
  localparam int NUM_EVT = 4;  // lane order: read_hit, read_miss, write_hit, write_miss

  localparam logic [CTRL_ADDR_W-1:0] A_HIT    = CTRL_ADDR_W'(0);
  localparam logic [CTRL_ADDR_W-1:0] A_MISS   = CTRL_ADDR_W'(1);
  localparam logic [CTRL_ADDR_W-1:0] A_RHIT   = CTRL_ADDR_W'(2);
  localparam logic [CTRL_ADDR_W-1:0] A_RMISS  = CTRL_ADDR_W'(3);
  localparam logic [CTRL_ADDR_W-1:0] A_WHIT   = CTRL_ADDR_W'(4);
  localparam logic [CTRL_ADDR_W-1:0] A_WMISS  = CTRL_ADDR_W'(5);
  localparam logic [CTRL_ADDR_W-1:0] A_RSTCNT = CTRL_ADDR_W'(6);
  localparam logic [CTRL_ADDR_W-1:0] A_INV    = CTRL_ADDR_W'(7);
  localparam logic [CTRL_ADDR_W-1:0] A_BEMPTY = CTRL_ADDR_W'(8);
  localparam logic [CTRL_ADDR_W-1:0] A_BFULL  = CTRL_ADDR_W'(9);
  localparam logic [CTRL_ADDR_W-1:0] A_FREEZE = CTRL_ADDR_W'(10);
  localparam logic [CTRL_ADDR_W-1:0] A_UNFRZ  = CTRL_ADDR_W'(11);
  localparam logic [CTRL_ADDR_W-1:0] A_STATUS = CTRL_ADDR_W'(12);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_DRAIN} state_t;

  state_t                        state_d, state_q;
  logic [FE_DATA_W-1:0]          rdata_d, rdata_q;
  logic                          inv_d, inv_q;
  logic                          frozen_d, frozen_q;

  logic [NUM_EVT-1:0]            evt;
  logic [NUM_EVT-1:0][CNT_W-1:0] cnt;
  logic [NUM_EVT-1:0]            ovf;
  logic                          accept, clr_cnt;
  logic [CNT_W:0]                hit_sum, miss_sum;
  logic [FE_DATA_W-1:0]          rd_val;

  assign evt     = {write_miss, write_hit, read_miss, read_hit};
  assign accept  = (state_q == S_IDLE) && valid;
  assign clr_cnt = accept && (addr == A_RSTCNT);

  genvar g;
  for (g = 0; g < NUM_EVT; g++) begin : g_cnt
    cache_perf_evt_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_cnt),
      .inc   (evt[g] & ~frozen_q),
      .cnt   (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  // Sums carry one extra bit; the cast then zero-extends or truncates.
  assign hit_sum  = {1'b0, cnt[0]} + {1'b0, cnt[2]};
  assign miss_sum = {1'b0, cnt[1]} + {1'b0, cnt[3]};

  always_comb begin
    rd_val = '0;
    case (addr)
      A_HIT:    rd_val = FE_DATA_W'(hit_sum);
      A_MISS:   rd_val = FE_DATA_W'(miss_sum);
      A_RHIT:   rd_val = FE_DATA_W'(cnt[0]);
      A_RMISS:  rd_val = FE_DATA_W'(cnt[1]);
      A_WHIT:   rd_val = FE_DATA_W'(cnt[2]);
      A_WMISS:  rd_val = FE_DATA_W'(cnt[3]);
      A_BEMPTY: rd_val = FE_DATA_W'(wtbuf_empty);
      A_BFULL:  rd_val = FE_DATA_W'(wtbuf_full);
      A_STATUS: rd_val = FE_DATA_W'({ovf, frozen_q});
      default:  rd_val = '0;
    endcase
  end

  // RESP is the single ready cycle for both paths; sitting in RESP while the
  // master still holds valid keeps the same request from being re-accepted.
  always_comb begin
    state_d  = state_q;
    rdata_d  = '0;
    inv_d    = 1'b0;
    frozen_d = frozen_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (addr == A_INV) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RESP;
            rdata_d = rd_val;
            if (addr == A_FREEZE) frozen_d = 1'b1;
            if (addr == A_UNFRZ)  frozen_d = 1'b0;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: begin
        if (wtbuf_empty) begin
          state_d = S_RESP;
          inv_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rdata_q  <= '0;
      inv_q    <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      inv_q    <= inv_d;
      frozen_q <= frozen_d;
    end
  end

  assign ready      = (state_q == S_RESP);
  assign rdata      = rdata_q;
  assign invalidate = inv_q;
endmodule

// File: tb/tb_cache_perf_ctrl.sv
module tb_cache_perf_ctrl;
  localparam int FW   = 32;
  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic [3:0]    addr;
  logic          wtbuf_full, wtbuf_empty;
  logic [3:0]    ev;  // {write_miss, write_hit, read_miss, read_hit}
  logic [FW-1:0] rdata;
  logic          ready, invalidate;

  int  vec = 0;
  int  err = 0;
  bit  rnd_ev = 0;

  // Reference model: plain event tallies.
  int  m_cnt[4];
  bit  m_ovf[4];
  bit  m_frz;

  cache_perf_ctrl #(.FE_DATA_W(FW), .CNT_W(CW), .CTRL_ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .addr        (addr),
    .wtbuf_full  (wtbuf_full),
    .wtbuf_empty (wtbuf_empty),
    .read_hit    (ev[0]),
    .read_miss   (ev[1]),
    .write_hit   (ev[2]),
    .write_miss  (ev[3]),
    .rdata       (rdata),
    .ready       (ready),
    .invalidate  (invalidate)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < 4; e++) begin
      m_cnt[e] = 0;
      m_ovf[e] = 0;
    end
  endtask

  // One clock: model consumes the inputs seen at this edge; acc is the address
  // accepted at this edge, or -1.
  task automatic tick(input int acc);
    @(posedge clk);
    if (reset) begin
      model_clear();
      m_frz = 0;
    end else begin
      if (acc == 6) model_clear();
      else begin
        for (int e = 0; e < 4; e++) begin
          if (ev[e] && !m_frz) begin
            if (m_cnt[e] == MAXV) begin
              m_ovf[e] = 1;
`ifdef CACHE_PERF_SAT_EN
              m_cnt[e] = MAXV;
`else
              m_cnt[e] = 0;
`endif
            end else m_cnt[e]++;
          end
        end
      end
      if (acc == 10) m_frz = 1;
      if (acc == 11) m_frz = 0;
    end
    @(negedge clk);
    if (rnd_ev) ev = 4'($urandom_range(0, 15));
    wtbuf_full = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [FW-1:0] reg_val(input int a);
    case (a)
      0:  return FW'(m_cnt[0] + m_cnt[2]);
      1:  return FW'(m_cnt[1] + m_cnt[3]);
      2, 3, 4, 5: return FW'(m_cnt[a-2]);
      8:  return FW'(wtbuf_empty);
      9:  return FW'(wtbuf_full);
      12: return FW'({m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0], m_frz});
      default: return '0;
    endcase
  endfunction

  task automatic do_req(input int a, output logic [FW-1:0] got);
    logic [FW-1:0] exp;
    valid = 1'b1;
    addr  = 4'(a);
    exp   = reg_val(a);
    tick(a);
    got = rdata;
    chk("req_ready", ready, 1);
    chk($sformatf("rdata_a%0d", a), rdata, exp);
    chk("req_no_inv", invalidate, 0);
    valid = 1'b0;
    tick(-1);
    chk("req_ready_low", ready, 0);
    chk("req_rdata_zero", rdata, 0);
  endtask

  // zeros = number of DRAIN cycles that see wtbuf_empty=0 before it rises.
  task automatic do_inval(input int zeros);
    bit e;
    valid = 1'b1;
    addr  = 4'd7;
    wtbuf_empty = (zeros == 0);
    tick(7);
    chk("inv_first_ready", ready, 0);
    chk("inv_first_inv", invalidate, 0);
    for (int i = 0; i <= zeros; i++) begin
      wtbuf_empty = (i >= zeros);
      tick(-1);
      e = (i >= zeros);
      chk($sformatf("inv_ready_c%0d", i + 2), ready, e);
      chk($sformatf("inv_pulse_c%0d", i + 2), invalidate, e);
      chk("inv_rdata", rdata, 0);
      if (e) break;
    end
    valid = 1'b0;
    tick(-1);
    chk("inv_ready_low", ready, 0);
    chk("inv_pulse_low", invalidate, 0);
  endtask

  initial begin
    logic [FW-1:0] got;
    reset = 1'b1; valid = 1'b0; addr = '0; wtbuf_full = 1'b0; wtbuf_empty = 1'b1; ev = '0;
    m_frz = 0;
    model_clear();
    @(negedge clk);
    tick(-1);
    tick(-1);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_inv", invalidate, 0);
    reset = 1'b0;
    do_req(12, got);
    chk("rst_status", got, 0);

    // Event count: read_hit and write_hit together for 5 cycles.
    ev = 4'b0101;
    repeat (5) tick(-1);
    ev = 4'b0000;
    do_req(0, got);
    chk("hit_sum10", got, 10);

    // Invalidate with buffer already empty, then delayed drain.
    do_inval(0);
    do_inval(5);

    // Clear wins over a read_miss strobe on the acceptance cycle.
    ev = 4'b0010;
    repeat (3) tick(-1);
    valid = 1'b1; addr = 4'd6;
    tick(6);
    ev = 4'b0000;
    chk("clr_ready", ready, 1);
    valid = 1'b0;
    tick(-1);
    do_req(3, got);
    chk("clear_wins", got, 0);

    // Overflow on write_miss.
    ev = 4'b1000;
    repeat (256) tick(-1);
    ev = 4'b0000;
    do_req(5, got);
`ifdef CACHE_PERF_SAT_EN
    chk("wmiss_ovf", got, 255);
`else
    chk("wmiss_ovf", got, 0);
`endif
    do_req(12, got);
    chk("status_ovf_wm", got[4], 1);

    // Freeze / unfreeze.
    do_req(6, got);
    do_req(10, got);
    ev = 4'b0001;
    repeat (3) tick(-1);
    ev = 4'b0000;
    do_req(12, got);
    chk("status_frozen", got[0], 1);
    do_req(11, got);
    ev = 4'b0001;
    repeat (2) tick(-1);
    ev = 4'b0000;
    do_req(2, got);
    chk("freeze_rhit", got, 2);
    do_req(12, got);
    chk("status_unfrozen", got[0], 0);

    // Reset while in DRAIN.
    wtbuf_empty = 1'b0;
    valid = 1'b1; addr = 4'd7;
    tick(7);
    valid = 1'b0;
    tick(-1);
    reset = 1'b1;
    tick(-1);
    chk("rstdrain_ready", ready, 0);
    chk("rstdrain_inv", invalidate, 0);
    reset = 1'b0;
    wtbuf_empty = 1'b1;
    repeat (4) begin
      tick(-1);
      chk("postrst_ready", ready, 0);
      chk("postrst_inv", invalidate, 0);
    end
    do_req(12, got);
    chk("postrst_status", got, 0);

    // Randomized requests with random event traffic.
    rnd_ev = 1;
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 15);
      if (op == 7) do_inval($urandom_range(0, 3));
      else begin
        wtbuf_empty = 1'($urandom_range(0, 1));
        do_req(op, got);
      end
      repeat ($urandom_range(0, 2)) tick(-1);
    end
    rnd_ev = 0;
    ev = '0;
    for (int a = 0; a < 6; a++) do_req(a, got);
    do_req(12, got);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/cache_perf_ctrl.md
CACHE_PERF_CTRL -- requirements
Module: cache_perf_ctrl

Interface
REQ-001 SHALL have parameter FE_DATA_W, default 32, front-end data width (valid range 8..64).
REQ-002 SHALL have parameter CNT_W, default 32, event counter width (valid range 8..FE_DATA_W).
REQ-003 SHALL have parameter CTRL_ADDR_W, default 4, control address width (minimum 4).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port valid, input, 1, control request; held by master until ready.
REQ-007 SHALL have port addr, input, CTRL_ADDR_W, control register address.
REQ-008 SHALL have ports wtbuf_full and wtbuf_empty, input, 1 each, write-through buffer status.
REQ-009 SHALL have ports read_hit, read_miss, write_hit, write_miss, input, 1 each, per-cycle event strobes.
REQ-010 SHALL have port rdata, output, FE_DATA_W, read data, valid only while ready=1.
REQ-011 SHALL have port ready, output, 1, one-cycle request acknowledge.
REQ-012 SHALL have port invalidate, output, 1, one-cycle cache invalidate pulse.

Function
REQ-013 SHALL decode the address map: 0 HIT, 1 MISS, 2 READ_HIT, 3 READ_MISS, 4 WRITE_HIT, 5 WRITE_MISS, 6 RESET_COUNTER, 7 INVALIDATE, 8 BUFFER_EMPTY, 9 BUFFER_FULL, 10 FREEZE, 11 UNFREEZE, 12 STATUS; all other addresses read 0 and take no action.
REQ-014 SHALL implement FSM states IDLE, RESP, DRAIN.
REQ-015 SHALL, in IDLE with valid=1 and addr!=7, accept the request, go to RESP and assert ready with rdata for exactly one cycle on the next cycle (latency 1); RESP always returns to IDLE.
REQ-016 SHALL, in IDLE with valid=1 and addr=7, go to DRAIN; in DRAIN, when wtbuf_empty=1, assert invalidate and ready together for exactly one cycle and return to IDLE.
REQ-017 SHALL make an invalidate request with wtbuf_empty=1 at acceptance complete two cycles after acceptance (one DRAIN cycle).
REQ-018 SHALL ignore valid while in RESP or DRAIN; a new request is accepted no earlier than the cycle after ready.
REQ-019 SHALL keep rdata at 0 whenever ready=0; rdata SHALL be the register value sampled in the acceptance cycle.
REQ-020 SHALL count the four events in independent CNT_W counters; simultaneous strobes in one cycle SHALL each increment their own counter.
REQ-021 SHALL return HIT = read_hit_cnt + write_hit_cnt and MISS = read_miss_cnt + write_miss_cnt, computed at CNT_W+1 bits, then zero-extended or truncated to FE_DATA_W.
REQ-022 SHALL zero-extend counter reads to FE_DATA_W; BUFFER_EMPTY and BUFFER_FULL SHALL return the status in bit 0.
REQ-023 SHALL, on an accepted RESET_COUNTER, clear all counters at the acceptance edge; events on that same cycle SHALL be lost (clear wins).
REQ-024 SHALL, on an accepted FREEZE or UNFREEZE, set or clear the frozen flag; while frozen, events SHALL be ignored, but RESET_COUNTER SHALL still clear the counters.
REQ-025 SHALL return STATUS as bit 0 = frozen and bits 4:1 = sticky overflow flags for read_hit, read_miss, write_hit and write_miss; the flags are cleared by RESET_COUNTER.
REQ-026 SHALL set a counter's overflow flag when an increment occurs at value all-ones.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, clear all counters, overflow flags and frozen, set the FSM to IDLE and drive rdata=0, ready=0 and invalidate=0.
REQ-028 SHALL abandon any in-flight request, including DRAIN, on reset without emitting ready or invalidate.

Configuration
REQ-029 SHALL support macro CACHE_PERF_SAT_EN: when defined, counters saturate at all-ones and further increments hold the value; when undefined, counters wrap to 0. In both cases the overflow flag per REQ-026 is set.

Verification
REQ-030 SHALL pass the event-count scenario: 5 cycles with read_hit=1 and write_hit=1 together, then read HIT (addr 0) -> ready 1 cycle after acceptance, rdata=10.
REQ-031 SHALL pass the drain scenario: wtbuf_empty=0, invalidate request, wtbuf_empty rises 6 cycles later -> invalidate=ready=1 in the same single cycle; no ready earlier.
REQ-032 SHALL pass the clear-wins scenario: RESET_COUNTER accepted in the same cycle as a read_miss strobe -> READ_MISS reads 0.
REQ-033 SHALL pass the overflow scenario: CNT_W=8, 256 write_miss strobes -> WRITE_MISS=255 with CACHE_PERF_SAT_EN and 0 without; STATUS bit 4=1 in both builds.
REQ-034 SHALL pass the freeze scenario: FREEZE, 3 read_hit strobes, UNFREEZE, 2 read_hit strobes -> READ_HIT=2 and STATUS bit 0=0.
REQ-035 SHALL pass the reset-during-DRAIN scenario: reset asserted in DRAIN, then wtbuf_empty=1 -> no invalidate and no ready pulse; the FSM is IDLE.
